// File: rtl/out_commutator_p.sv
// Output commutator for the pipelined FFT back end: bit-reversed lane permutation
// followed by per-lane ping-pong frame reordering into natural or bit-reversed order.
module out_commutator_p #(
    parameter int NB    = 16,
    parameter int LANES = 4,
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic                mode,
    input  logic [NB*LANES-1:0] input_data,
    output logic [NB*LANES-1:0] output_data,
    output logic                out_valid,
    output logic                out_start,
    output logic                frame_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LANES);

    function automatic int bitrev_f(input int v, input int w);
        int r;
        r = 0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) r = r | (1 << (w - 1 - i));
        end
        return r;
    endfunction

    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic {R_IDLE, R_RUN}  r_state_t;

    w_state_t      w_state_q, w_state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          wr_en, wr_swap, wr_err;
    logic [AW-1:0] wr_addr;

    r_state_t      r_state_q, r_state_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d, rd_cnt_rev, rd_addr;
    logic          rd_mode_q, rd_mode_d, rd_en;

    logic          out_valid_q, out_start_q, frame_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state_q   <= W_IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            r_state_q   <= R_IDLE;
            rd_cnt_q    <= '0;
            rd_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            r_state_q   <= r_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_mode_q   <= rd_mode_d;
            out_valid_q <= rd_en;
            out_start_q <= rd_en && (rd_cnt_q == '0);
            frame_err_q <= wr_err;
        end
    end

    // A start always rewrites address 0; it is an error only if a frame was partly filled.
    always_comb begin
        wr_en   = in_valid && (start || (w_state_q == W_FILL));
        wr_addr = start ? '0 : wr_cnt_q;
        wr_swap = wr_en && !start && (wr_cnt_q == AW'(DEPTH - 1));
        wr_err  = wr_en && start && (w_state_q == W_FILL) && (wr_cnt_q != '0);
    end

    always_comb begin
        w_state_d = w_state_q;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (wr_en) begin
            w_state_d = W_FILL;
            wr_cnt_d  = start ? AW'(1) : wr_cnt_q + 1'b1;
        end
        if (wr_swap) wr_bank_d = ~wr_bank_q;
    end

    // A swap on the final read cycle restarts the readout so out_valid stays continuous.
    always_comb begin
        r_state_d = r_state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_mode_d = rd_mode_q;
        if (r_state_q == R_RUN) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == AW'(DEPTH - 1)) r_state_d = R_IDLE;
        end
        if (wr_swap) begin
            r_state_d = R_RUN;
            rd_cnt_d  = '0;
            rd_mode_d = mode;
        end
    end

    always_comb begin
        rd_en   = (r_state_q == R_RUN);
        rd_addr = rd_mode_q ? rd_cnt_rev : rd_cnt_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_rev
            assign rd_cnt_rev[gi] = rd_cnt_q[AW-1-gi];
        end

        // The read bank is always the one not being written.
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int SRC = bitrev_f(gi, LW);
            logic [NB-1:0] mem [0:2*DEPTH-1];
            logic [NB-1:0] lane_q;

            always_ff @(posedge clk) begin
                if (wr_en) mem[{wr_bank_q, wr_addr}] <= input_data[NB*SRC +: NB];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)   lane_q <= '0;
                else if (rd_en) lane_q <= mem[{~wr_bank_q, rd_addr}];
            end

            assign output_data[NB*gi +: NB] = lane_q;
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign out_start = out_start_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_out_commutator_p.sv
// Directed bench for out_commutator_p with LANES=4, DEPTH=8, NB=16.
module tb_out_commutator_p;
    localparam int NB    = 16;
    localparam int LANES = 4;
    localparam int DEPTH = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic                mode = 1'b0;
    logic [NB*LANES-1:0] input_data = '0;
    logic [NB*LANES-1:0] output_data;
    logic                out_valid, out_start, frame_err;

    always #5 clk = ~clk;

    out_commutator_p #(.NB(NB), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .mode(mode),
        .input_data(input_data), .output_data(output_data),
        .out_valid(out_valid), .out_start(out_start), .frame_err(frame_err)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [63:0] obs_data [$];
    bit          obs_start[$];
    int          obs_cycle[$];
    int          err_q    [$];

    logic [15:0] lane1_rev [8] = '{16'h200, 16'h204, 16'h202, 16'h206, 16'h201, 16'h205, 16'h203, 16'h207};
    logic [15:0] lane3_rev [8] = '{16'h300, 16'h304, 16'h302, 16'h306, 16'h301, 16'h305, 16'h303, 16'h307};

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) begin
                obs_data.push_back(output_data);
                obs_start.push_back(out_start);
                obs_cycle.push_back(cyc);
            end
            if (frame_err) err_q.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane k reads input lane bitrev2(k); index j maps to address bitrev3(j) in reversed mode.
    function automatic logic [63:0] exp_word(input int off, input bit m, input int j);
        logic [63:0] w;
        int src, addr;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            src  = (k & 1) * 2 + ((k >> 1) & 1);
            addr = m ? ((j & 1) * 4 + ((j >> 1) & 1) * 2 + ((j >> 2) & 1)) : j;
            w[16*k +: 16] = 16'(src * 256 + addr + off);
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid   = 1'b0;
        start      = 1'b0;
        input_data = {4{16'hDEAD}};
        repeat (n) step();
    endtask

    task automatic send_frame(input int off, input bit m, input bit with_start, input int nsamp,
                              input bit gaps, output int first_edge);
        first_edge = -1;
        for (int n = 0; n < nsamp; n++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 2));
            in_valid = 1'b1;
            start    = with_start && (n == 0);
            mode     = m;
            for (int l = 0; l < 4; l++) input_data[16*l +: 16] = 16'(l * 256 + n + off);
            if (n == 0) first_edge = cyc + 1;
            step();
        end
    endtask

    task automatic check_frames(input string tag, input int nfr, input int offs[3], input bit modes[3],
                                input int first_edge, input bit contig);
        int f, j, ref_cyc;
        chk({tag, "_count"}, obs_data.size(), nfr * 8);
        chk({tag, "_err"}, err_q.size(), 0);
        if (first_edge >= 0 && obs_cycle.size() > 0)
            chk({tag, "_latency"}, obs_cycle[0], first_edge + 8);
        for (int i = 0; i < obs_data.size() && i < nfr * 8; i++) begin
            f = i / 8;
            j = i % 8;
            chk({tag, "_data"}, obs_data[i], exp_word(offs[f], modes[f], j));
            chk({tag, "_start"}, obs_start[i], j == 0);
            if (i > 0 && (contig || j > 0)) begin
                ref_cyc = contig ? obs_cycle[0] + i : obs_cycle[f*8] + j;
                chk({tag, "_gapless"}, obs_cycle[i], ref_cyc);
            end
        end
        for (int i = 0; i < nfr; i++) $display("%s frame %0d checked", tag, i);
        obs_data.delete();
        obs_start.delete();
        obs_cycle.delete();
        err_q.delete();
    endtask

    initial begin
        int fe, fe2;
        input_data = '0;
        repeat (3) step();
        chk("rst_data", output_data, 64'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_start", out_start, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        reset_n = 1'b1;

        // in_valid without start after reset is dropped
        in_valid = 1'b1;
        start    = 1'b0;
        for (int n = 0; n < 10; n++) begin
            input_data = {4{16'(n + 16'h0A00)}};
            step();
        end
        idle(14);
        chk("nostart_out", obs_data.size(), 0);
        chk("nostart_err", err_q.size(), 0);
        $display("nostart checked");

        // A: reversed readout
        send_frame(0, 1'b1, 1'b1, 8, 1'b0, fe);
        idle(12);
        if (obs_data.size() >= 8) begin
            for (int j = 0; j < 8; j++) begin
                chk("A_lane1", obs_data[j][31:16], lane1_rev[j]);
                chk("A_lane3", obs_data[j][63:48], lane3_rev[j]);
            end
        end
        check_frames("A", 1, '{0, 0, 0}, '{1'b1, 1'b0, 1'b0}, fe, 1'b1);

        // B: natural readout
        send_frame(0, 1'b0, 1'b1, 8, 1'b0, fe);
        idle(12);
        if (obs_data.size() >= 8) begin
            for (int j = 0; j < 8; j++) begin
                chk("B_lane2", obs_data[j][47:32], 16'(16'h100 + j));
                chk("B_lane0", obs_data[j][15:0], 16'(j));
            end
        end
        check_frames("B", 1, '{0, 0, 0}, '{1'b0, 1'b0, 1'b0}, fe, 1'b1);

        // C: three back-to-back frames, mode 1,0,1, start only on the first
        send_frame(16'h10, 1'b1, 1'b1, 8, 1'b0, fe);
        send_frame(16'h20, 1'b0, 1'b0, 8, 1'b0, fe2);
        send_frame(16'h30, 1'b1, 1'b0, 8, 1'b0, fe2);
        idle(12);
        check_frames("C", 3, '{16'h10, 16'h20, 16'h30}, '{1'b1, 1'b0, 1'b1}, fe, 1'b1);

        // D: random gaps in in_valid
        send_frame(16'h80, 1'b1, 1'b1, 8, 1'b1, fe);
        send_frame(16'h90, 1'b0, 1'b0, 8, 1'b1, fe2);
        idle(12);
        check_frames("D", 2, '{16'h80, 16'h90, 0}, '{1'b1, 1'b0, 1'b0}, -1, 1'b0);

        // E: restart after 5 samples discards the partial frame
        send_frame(16'h40, 1'b1, 1'b1, 5, 1'b0, fe);
        send_frame(16'h50, 1'b0, 1'b1, 8, 1'b0, fe2);
        idle(12);
        chk("E_err_count", err_q.size(), 1);
        if (err_q.size() >= 1) chk("E_err_cycle", err_q[0], fe2);
        err_q.delete();
        check_frames("E", 1, '{16'h50, 0, 0}, '{1'b0, 1'b0, 1'b0}, fe2, 1'b1);

        // F: asynchronous reset mid-readout, then a fresh frame
        send_frame(16'h60, 1'b0, 1'b1, 8, 1'b0, fe);
        in_valid = 1'b0;
        start    = 1'b0;
        for (int t = 0; t < 20 && obs_data.size() < 3; t++) idle(1);
        chk("F_midread", obs_data.size() >= 3, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("F_rst_data", output_data, 64'h0);
        chk("F_rst_valid", out_valid, 1'b0);
        chk("F_rst_start", out_start, 1'b0);
        chk("F_rst_err", frame_err, 1'b0);
        obs_data.delete();
        obs_start.delete();
        obs_cycle.delete();
        err_q.delete();
        idle(2);
        reset_n = 1'b1;
        idle(2);
        send_frame(16'h70, 1'b1, 1'b1, 8, 1'b0, fe);
        idle(12);
        check_frames("F", 1, '{16'h70, 0, 0}, '{1'b1, 1'b0, 1'b0}, fe, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/out_commutator_p.md
# out_commutator_p

Parametrised output commutator for the pipelined FFT back end. It accepts LANES parallel sample streams from the last butterfly stage, with one NB-bit word per lane per accepted cycle. It permutes the lanes by bit-reversed lane index, then reorders each lane's DEPTH-sample frame into natural or bit-reversed order through a per-lane ping-pong buffer. It adds a valid handshake, frame framing, a runtime order mode and partial-frame error detection.

## Interface
- NB, 16, bits per sample word
- LANES, 4, number of parallel lanes; power of 2, ≥2
- DEPTH, 16, samples per lane per frame; power of 2, ≥2
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  marks the first sample of a frame; qualified by in_valid
- in_valid  in  1  input_data valid this cycle
- mode  in  1  1 = bit-reversed readout, 0 = natural readout
- input_data  in  NB*LANES  lane l occupies [NB*(l+1)-1:NB*l]
- output_data  out  NB*LANES  lane k occupies [NB*(k+1)-1:NB*k]
- out_valid  out  1  output_data valid
- out_start  out  1  first output word of a frame
- frame_err  out  1  one-cycle pulse when a partial frame is discarded

## Operation
- Lane map: output lane k is fed by input lane bitrev(k) over log2(LANES) bits. For LANES=4: 0←0, 1←2, 2←1, 3←3.
- Each lane has two banks of DEPTH×NB. All lanes share the write and read control.
- Write FSM has two states, W_IDLE and W_FILL.
  - W_IDLE: in_valid without start is dropped. start&in_valid writes address 0, sets wr_cnt=1 and goes to W_FILL.
  - W_FILL: each in_valid writes address wr_cnt of the write bank, then wr_cnt++.
  - start&in_valid with wr_cnt≠0 discards the partial frame and pulses frame_err on the next cycle. The sample is written to address 0, wr_cnt=1, and the bank is not swapped.
  - The edge that writes address DEPTH-1 swaps the banks, wr_cnt wraps to 0 and the FSM stays in W_FILL. The next frame needs no start. A start at wr_cnt=0 is legal and causes no error.
- Read FSM has two states, R_IDLE and R_RUN.
  - The bank swap enters R_RUN with rd_cnt=0 and latches the mode value present at the swap edge as rd_mode.
  - In R_RUN, rd_cnt increments every cycle with no stall. The read address is rd_mode ? bitrev(rd_cnt) : rd_cnt over log2(DEPTH) bits.
  - After rd_cnt=DEPTH-1 the FSM returns to R_IDLE. If a swap occurs on the same edge, it restarts at rd_cnt=0 with out_valid held continuous.
- Overrun cannot occur: a fill takes ≥DEPTH accepted cycles and a read takes exactly DEPTH cycles.
- Width rules: counters are log2(DEPTH) bits and wrap naturally. Data passes through unmodified with no arithmetic.
- Reset (also mid-frame) forces both FSMs idle, clears counters and bank select, and sets output_data=0, out_valid=0, out_start=0, frame_err=0. RAM contents are don't-care. Any partial frame is lost.

## Timing
- All outputs are registered.
- Edge N writes the last sample of a frame. At edge N+1 the output register holds read index 0, with out_valid=1 and out_start=1. Indices 1..DEPTH-1 follow on edges N+2..N+DEPTH.
- At full input rate the latency from first sample accepted to first sample out is exactly DEPTH cycles, and the output stream is gapless.
- When out_valid=0, output_data holds its last value. Only out_valid qualifies the data.
- frame_err is high for exactly the one cycle after the offending edge.
- Gaps in in_valid stretch the fill but do not affect an ongoing readout.

## Test plan
- LANES=4, DEPTH=8, NB=16, mode=1, continuous frame with input lane l sample n = l·256+n, start on n=0 → out_valid rises 8 cycles after the first input. Lane 1 outputs 0x200,0x204,0x202,0x206,0x201,0x205,0x203,0x207. Lane 3 outputs 0x300,0x304,…. out_start is high only on the first word.
- Same stimulus with mode=0 → lane 2 outputs 0x100..0x107 in order. Lane 0 outputs 0x000..0x007.
- Three back-to-back frames with no gaps, mode toggling 1,0,1 at each swap → 24 consecutive out_valid cycles, out_start at words 0, 8 and 16, and each frame's order follows the mode latched at its own swap.
- in_valid randomly low 50% of cycles → every frame's output is identical to the continuous case. Each readout burst is 8 consecutive cycles.
- start after 5 samples → frame_err pulses for one cycle, the first 5 samples never appear, and the following 8-sample frame outputs correctly. in_valid without a prior start after reset → no output.
- Assert reset_n=0 mid-readout → all outputs are 0 immediately and asynchronously. After release, a fresh frame is output correctly with no stale words.
